// File: rtl/sseg_edit_ctrl.sv
// Seven-segment value editor: committed value plus shadow edit buffer, cursor and inactivity abort.
// Optional macro SSEG_EDIT_DEC_EN restricts editing to decimal digits 0-9.
module sseg_edit_ctrl #(
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] value,
  output logic [31:0] disp_value,
  output logic [2:0]  active_segment,
  output logic        editing,
  output logic        commit_pulse
);

  // state  | meaning
  // IDLE   | showing committed value, waiting for enter
  // EDIT   | editing shadow buffer, cursor digit blinks
  // COMMIT | one cycle: edit buffer copied into value
  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_value, w_value_nxt;
  logic [31:0]   r_edit_buf, w_edit_buf_nxt;
  logic [2:0]    r_cursor, w_cursor_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [4:0]    w_bit_idx;
  logic [3:0]    w_nib, w_nib_inc, w_nib_dec;
  logic          w_any_btn;
  logic          w_timeout;

  assign w_bit_idx = {r_cursor, 2'b00};
  assign w_nib     = r_edit_buf[w_bit_idx +: 4];
  assign w_any_btn = btn_left | btn_right | btn_up | btn_down | btn_enter;
  // Leave on the edge at which the timer would reach TIMEOUT_CYCLES-1.
  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 2));

`ifdef SSEG_EDIT_DEC_EN
  assign w_nib_inc = (w_nib >= 4'd9) ? 4'd0 : w_nib + 4'd1;
  assign w_nib_dec = (w_nib == 4'd0 || w_nib > 4'd9) ? 4'd9 : w_nib - 4'd1;

  function automatic logic [31:0] f_load(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction
`else
  assign w_nib_inc = w_nib + 4'd1;
  assign w_nib_dec = w_nib - 4'd1;

  function automatic logic [31:0] f_load(input logic [31:0] v);
    return v;
  endfunction
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_value_nxt    = r_value;
    w_edit_buf_nxt = r_edit_buf;
    w_cursor_nxt   = r_cursor;
    w_timer_nxt    = r_timer;

    if (wr_en) begin
      // Host write wins over everything and aborts any session.
      w_value_nxt = wr_data;
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_timer_nxt = '0;
          if (btn_enter) begin
            w_state_nxt    = S_EDIT;
            w_edit_buf_nxt = f_load(r_value);
            w_cursor_nxt   = 3'd0;
          end
        end
        S_EDIT: begin
          if (w_any_btn) w_timer_nxt = '0;
          else           w_timer_nxt = r_timer + TW'(1);
          if (btn_enter) begin
            w_state_nxt = S_COMMIT;
            w_timer_nxt = '0;
          end else if (btn_up) begin
            w_edit_buf_nxt[w_bit_idx +: 4] = w_nib_inc;
          end else if (btn_down) begin
            w_edit_buf_nxt[w_bit_idx +: 4] = w_nib_dec;
          end else if (btn_left) begin
            w_cursor_nxt = r_cursor + 3'd1;
          end else if (btn_right) begin
            w_cursor_nxt = r_cursor - 3'd1;
          end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
          end
        end
        S_COMMIT: begin
          w_value_nxt = r_edit_buf;
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_value    <= '0;
      r_edit_buf <= '0;
      r_cursor   <= '0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_value    <= w_value_nxt;
      r_edit_buf <= w_edit_buf_nxt;
      r_cursor   <= w_cursor_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  assign value          = r_value;
  assign editing        = (r_state == S_EDIT);
  assign commit_pulse   = (r_state == S_COMMIT);
  assign disp_value     = editing ? r_edit_buf : r_value;
  assign active_segment = editing ? r_cursor : 3'd0;

endmodule

// File: tb/tb_sseg_edit_ctrl.sv
// Directed bench for sseg_edit_ctrl with a short inactivity timeout.
module tb_sseg_edit_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] value, disp_value;
  logic [2:0]  active_segment;
  logic        editing, commit_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic seen_commit;

  localparam logic [4:0] B_ENTER = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  sseg_edit_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_enter(btn_enter),
    .wr_en(wr_en), .wr_data(wr_data),
    .value(value), .disp_value(disp_value), .active_segment(active_segment),
    .editing(editing), .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {btn_enter, btn_up, btn_down, btn_left, btn_right} = b;
    tick();
    {btn_enter, btn_up, btn_down, btn_left, btn_right} = 5'b0;
  endtask

  task automatic host_wr(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      seen_commit |= commit_pulse;
    end
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", value, 32'h0);
    chk("rst_disp", disp_value, 32'h0);
    chk("rst_seg", 32'(active_segment), 32'h0);
    chk("rst_edit", 32'(editing), 32'h0);
    chk("rst_commit", 32'(commit_pulse), 32'h0);
    reset_n = 1'b1;
    tick();

    host_wr(32'h1234_ABCD);
    chk("wr_value", value, 32'h1234_ABCD);
    chk("wr_disp", disp_value, 32'h1234_ABCD);
    chk("wr_edit", 32'(editing), 32'h0);
    chk("wr_seg", 32'(active_segment), 32'h0);

    // Digit wrap at top of range and commit timing
    host_wr(32'h0000_000F);
    press(B_ENTER);
    chk("enter_edit", 32'(editing), 32'h1);
`ifdef SSEG_EDIT_DEC_EN
    chk("enter_buf", disp_value, 32'h0);
    press(B_UP);
    chk("up_wrap", disp_value, 32'h1);
`else
    chk("enter_buf", disp_value, 32'h0000_000F);
    press(B_UP);
    chk("up_wrap", disp_value, 32'h0);
`endif
    press(B_ENTER);
    chk("commit_hi", 32'(commit_pulse), 32'h1);
    chk("commit_oldval", value, 32'h0000_000F);
    chk("commit_edit", 32'(editing), 32'h0);
    tick();
    chk("commit_lo", 32'(commit_pulse), 32'h0);
`ifdef SSEG_EDIT_DEC_EN
    chk("commit_val", value, 32'h1);
`else
    chk("commit_val", value, 32'h0);
`endif

    // Cursor wrap both ways, decrement wrap
    host_wr(32'h0);
    press(B_ENTER);
    press(B_RIGHT);
    chk("right_wrap", 32'(active_segment), 32'h7);
    press(B_DOWN);
`ifdef SSEG_EDIT_DEC_EN
    chk("down_wrap", disp_value, 32'h9000_0000);
`else
    chk("down_wrap", disp_value, 32'hF000_0000);
`endif
    press(B_LEFT);
    chk("left_wrap", 32'(active_segment), 32'h0);

    // Host write aborts the session
    host_wr(32'h0);
    chk("abort_edit", 32'(editing), 32'h0);
    chk("abort_disp", disp_value, 32'h0);

    // up beats left
    press(B_ENTER);
    press(B_UP | B_LEFT);
    chk("prio_disp", disp_value, 32'h1);
    chk("prio_seg", 32'(active_segment), 32'h0);

    // Host write with enter in EDIT
    wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; btn_enter = 1'b1;
    tick();
    wr_en = 1'b0; btn_enter = 1'b0;
    chk("host_val", value, 32'hDEAD_BEEF);
    chk("host_edit", 32'(editing), 32'h0);
    chk("host_commit", 32'(commit_pulse), 32'h0);
    tick();
    chk("host_commit2", 32'(commit_pulse), 32'h0);
    chk("host_val2", value, 32'hDEAD_BEEF);

    // Host write with enter in IDLE: no edit starts
    wr_en = 1'b1; wr_data = 32'h0000_0005; btn_enter = 1'b1;
    tick();
    wr_en = 1'b0; btn_enter = 1'b0;
    chk("idle_wr_edit", 32'(editing), 32'h0);
    chk("idle_wr_val", value, 32'h0000_0005);

    // Inactivity timeout
    seen_commit = 1'b0;
    press(B_ENTER);
    press(B_UP);
    chk("to_disp", disp_value, 32'h0000_0006);
    idle(14);
    chk("to_still", 32'(editing), 32'h1);
    idle(1);
    chk("to_exit", 32'(editing), 32'h0);
    chk("to_value", value, 32'h0000_0005);
    chk("to_disp_back", disp_value, 32'h0000_0005);
    chk("to_nocommit", 32'(seen_commit), 32'h0);

    // A pulse at idle cycle 14 restarts the count
    press(B_ENTER);
    idle(13);
    press(B_LEFT);
    chk("rs_seg", 32'(active_segment), 32'h1);
    idle(14);
    chk("rs_still", 32'(editing), 32'h1);
    idle(1);
    chk("rs_exit", 32'(editing), 32'h0);

    // Asynchronous reset in EDIT
    press(B_ENTER);
    press(B_UP);
    chk("pre_rst_edit", 32'(editing), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_value", value, 32'h0);
    chk("arst_disp", disp_value, 32'h0);
    chk("arst_seg", 32'(active_segment), 32'h0);
    chk("arst_edit", 32'(editing), 32'h0);
    chk("arst_commit", 32'(commit_pulse), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
